returns_compounder: RTL and testbench

// Inverse of the price->returns path. Consumes one per-stock return vector per step (Q8.8

---
 rtl/returns_compounder.sv | 240 ++++++++++++++++++++++++
 tb/tb_returns_compounder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/returns_compounder.sv
// returns_compounder
// Compounds per-stock growth factors g_i *= (1 + r_i) once per accepted step,
// then reports value = capital * sum(w_i * g_i) in whole dollars. All products
// go through one shared multiplier whose operands are chosen by the FSM phase.
// Lane i occupies bits [16*i +: 16] of returns_i, weights_i and growth_o.
// Build option: define COMPOUNDER_SATURATE_EN to saturate the g_i and value
// narrowing instead of keeping the low bits (two's-complement wrap).
module returns_compounder #(
    parameter int N_STOCKS = 3,
    parameter int FRAC     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  valid_in_i,
    output logic                  ready_out_o,
    input  logic [N_STOCKS*16-1:0] returns_i,
    input  logic [N_STOCKS*16-1:0] weights_i,
    input  logic [15:0]           capital_i,
    output logic                  valid_out_o,
    input  logic                  ready_in_i,
    output logic [31:0]           value_o,
    output logic [N_STOCKS*16-1:0] growth_o,
    output logic [7:0]            step_count_o
);

    localparam int LW = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam logic [LW-1:0]      LANE_LAST = LW'(N_STOCKS - 1);
    localparam logic signed [15:0] G_ONE     = 16'(1 << FRAC);
    localparam logic signed [16:0] F_ONE     = 17'(1 << FRAC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPOUND,
        S_WEIGHT,
        S_SCALE,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic signed [15:0]    g_q   [N_STOCKS];
    logic signed [15:0]    g_d   [N_STOCKS];
    logic signed [15:0]    ret_q [N_STOCKS];
    logic signed [15:0]    ret_d [N_STOCKS];
    logic signed [15:0]    wgt_q [N_STOCKS];
    logic signed [15:0]    wgt_d [N_STOCKS];
    logic [15:0]           cap_q, cap_d;
    logic signed [35:0]    acc_q, acc_d;
    logic signed [31:0]    value_q, value_d;
    logic                  valid_out_q, valid_out_d;
    logic [7:0]            step_q, step_d;
    logic [7:0]            step_base;

    logic signed [16:0]    r_ext, f;
    logic signed [35:0]    mul_a;
    logic signed [17:0]    mul_b;
    logic signed [53:0]    mul_p;
    logic signed [53:0]    g_shift, v_shift;
    logic signed [15:0]    g_new;
    logic signed [31:0]    value_new;
    logic                  unused_hi;

    // Next-state logic: walk the lanes twice, scale once, then hold for the consumer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in_i) begin
                    state_d = S_COMPOUND;
                    lane_d  = '0;
                end
            end
            S_COMPOUND: begin
                if (lane_q == LANE_LAST) begin
                    state_d = S_WEIGHT;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_WEIGHT: begin
                if (lane_q == LANE_LAST) begin
                    state_d = S_SCALE;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_SCALE: state_d = S_HOLD;
            S_HOLD: begin
                if (valid_out_q && ready_in_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared multiplier operand select; the growth factor (1 + r) is floored at zero.
    always_comb begin
        r_ext = '0;
        f     = '0;
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_COMPOUND: begin
                r_ext = {ret_q[lane_q][15], ret_q[lane_q]};
                f     = r_ext + F_ONE;
                if (f[16]) begin
                    f = '0;
                end
                mul_a = {{20{g_q[lane_q][15]}}, g_q[lane_q]};
                mul_b = {f[16], f};
            end
            S_WEIGHT: begin
                mul_a = {{20{wgt_q[lane_q][15]}}, wgt_q[lane_q]};
                mul_b = {{2{g_q[lane_q][15]}}, g_q[lane_q]};
            end
            S_SCALE: begin
                mul_a = acc_q;
                mul_b = {2'b00, cap_q};
            end
            default: ;
        endcase
    end

    assign mul_p   = mul_a * mul_b;
    assign g_shift = mul_p >>> FRAC;
    assign v_shift = mul_p >>> (2 * FRAC);

    // Upper bits only matter when saturating; fold them so they are visibly consumed.
    assign unused_hi = ^{g_shift[53:16], v_shift[53:32]};

    // Narrow the rescaled products back to the register widths.
    always_comb begin
`ifdef COMPOUNDER_SATURATE_EN
        if (g_shift > 54'sd32767) begin
            g_new = 16'sh7fff;
        end else if (g_shift < -54'sd32768) begin
            g_new = 16'sh8000;
        end else begin
            g_new = g_shift[15:0];
        end
        if (v_shift > 54'sd2147483647) begin
            value_new = 32'sh7fff_ffff;
        end else if (v_shift < -54'sd2147483648) begin
            value_new = 32'sh8000_0000;
        end else begin
            value_new = v_shift[31:0];
        end
`else
        g_new     = g_shift[15:0];
        value_new = v_shift[31:0];
`endif
    end

    // Datapath next-state: latch on accept, update one lane per cycle, scale, handshake.
    always_comb begin
        g_d         = g_q;
        ret_d       = ret_q;
        wgt_d       = wgt_q;
        cap_d       = cap_q;
        acc_d       = acc_q;
        value_d     = value_q;
        valid_out_d = valid_out_q;
        step_d      = step_q;
        step_base   = step_q;
        case (state_q)
            S_IDLE: begin
                // A clear in the same cycle as an accept takes effect first.
                if (clear_i) begin
                    for (int i = 0; i < N_STOCKS; i++) begin
                        g_d[i] = G_ONE;
                    end
                    step_base = '0;
                    step_d    = '0;
                end
                if (valid_in_i) begin
                    for (int i = 0; i < N_STOCKS; i++) begin
                        ret_d[i] = returns_i[16*i +: 16];
                        wgt_d[i] = weights_i[16*i +: 16];
                    end
                    cap_d  = capital_i;
                    acc_d  = '0;
                    step_d = (step_base == 8'hFF) ? step_base : step_base + 8'd1;
                end
            end
            S_COMPOUND: g_d[lane_q] = g_new;
            S_WEIGHT:   acc_d = acc_q + {{4{mul_p[31]}}, mul_p[31:0]};
            S_SCALE:    value_d = value_new;
            S_HOLD:     valid_out_d = !(valid_out_q && ready_in_i);
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            // NOTE: the small lane arrays are reset as plain registers; g_i must restart at 1.0,
            // and resetting the input latches too keeps a single register process.
            for (int i = 0; i < N_STOCKS; i++) begin
                g_q[i]   <= G_ONE;
                ret_q[i] <= '0;
                wgt_q[i] <= '0;
            end
            cap_q       <= '0;
            acc_q       <= '0;
            value_q     <= '0;
            valid_out_q <= 1'b0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            g_q         <= g_d;
            ret_q       <= ret_d;
            wgt_q       <= wgt_d;
            cap_q       <= cap_d;
            acc_q       <= acc_d;
            value_q     <= value_d;
            valid_out_q <= valid_out_d;
            step_q      <= step_d;
        end
    end

    assign ready_out_o  = (state_q == S_IDLE);
    assign valid_out_o  = valid_out_q;
    assign value_o      = value_q;
    assign step_count_o = step_q;

    for (genvar gi = 0; gi < N_STOCKS; gi++) begin : g_growth
        assign growth_o[16*gi +: 16] = g_q[gi];
    end

endmodule

// File: tb/tb_returns_compounder.sv
// Self-checking bench for returns_compounder (N_STOCKS=3). A step-level model
// computes growth factors and value with plain integer arithmetic; a negedge
// process compares every meaningful output each cycle, and directed steps pin
// the model with hand-computed numbers. Randomized steps follow.
module tb_returns_compounder;

    localparam int N = 3;

`ifdef COMPOUNDER_SATURATE_EN
    localparam longint T4_G0 = 32767;
`else
    localparam longint T4_G0 = -32513;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clear_i = 1'b0;
    logic           valid_in_i = 1'b0;
    logic           ready_in_i = 1'b0;
    logic [N*16-1:0] returns_i = '0;
    logic [N*16-1:0] weights_i = '0;
    logic [15:0]    capital_i = '0;
    logic           ready_out_o;
    logic           valid_out_o;
    logic [31:0]    value_o;
    logic [N*16-1:0] growth_o;
    logic [7:0]     step_count_o;

    returns_compounder #(.N_STOCKS(N), .FRAC(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .valid_in_i   (valid_in_i),
        .ready_out_o  (ready_out_o),
        .returns_i    (returns_i),
        .weights_i    (weights_i),
        .capital_i    (capital_i),
        .valid_out_o  (valid_out_o),
        .ready_in_i   (ready_in_i),
        .value_o      (value_o),
        .growth_o     (growth_o),
        .step_count_o (step_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    bit     m_idle;
    bit     m_vout;
    int     m_cnt;
    int     m_step;
    longint m_value;
    longint m_g [N];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint narrow16(input longint x);
        logic [15:0] t;
`ifdef COMPOUNDER_SATURATE_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
`endif
        t = x[15:0];
        return longint'($signed(t));
    endfunction

    function automatic longint narrow32(input longint x);
        logic [31:0] t;
`ifdef COMPOUNDER_SATURATE_EN
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
`endif
        t = x[31:0];
        return longint'($signed(t));
    endfunction

    function automatic longint lane_of(input logic [N*16-1:0] bus, input int i);
        logic [15:0] t;
        t = bus[16*i +: 16];
        return longint'($signed(t));
    endfunction

    function automatic logic [N*16-1:0] pack3(input int a, input int b, input int c);
        logic [15:0] la, lb, lc;
        la = a[15:0];
        lb = b[15:0];
        lc = c[15:0];
        return {lc, lb, la};
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_vout  = 1'b0;
        m_cnt   = 0;
        m_step  = 0;
        m_value = 0;
        for (int i = 0; i < N; i++) m_g[i] = 256;
    endtask

    // One whole step at the level of the arithmetic rules.
    task automatic model_accept();
        longint f, acc;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            f = 256 + lane_of(returns_i, i);
            if (f < 0) f = 0;
            m_g[i] = narrow16((m_g[i] * f) >>> 8);
        end
        for (int i = 0; i < N; i++) acc += lane_of(weights_i, i) * m_g[i];
        m_value = narrow32((acc * longint'(capital_i)) >>> 16);
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge will see.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("ready_out", ready_out_o, m_idle);
                check("valid_out", valid_out_o, m_vout);
                check("step_count", step_count_o, m_step);
                if (m_vout) check("value", $signed(value_o), m_value);
                if (m_idle || m_vout) begin
                    for (int i = 0; i < N; i++) check($sformatf("growth%0d", i), lane_of(growth_o, i), m_g[i]);
                end
            end
            if (!rst_n) begin
                model_reset();
            end else if (m_idle) begin
                if (clear_i) begin
                    for (int i = 0; i < N; i++) m_g[i] = 256;
                    m_step = 0;
                end
                if (valid_in_i) begin
                    model_accept();
                    m_step = (m_step == 255) ? 255 : m_step + 1;
                    m_idle = 1'b0;
                    m_cnt  = 0;
                end
            end else if (m_vout) begin
                if (ready_in_i) begin
                    m_vout = 1'b0;
                    m_idle = 1'b1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 2 * N + 2) m_vout = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready_out_o !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        if (ready_out_o !== 1'b1) check("ready_out_wait", ready_out_o, 1);
    endtask

    task automatic run_step(input logic [N*16-1:0] r, input logic [N*16-1:0] w, input logic [15:0] cap,
                            input bit clr, input int hold, input bit noise,
                            output int lat, output longint val);
        wait_ready();
        returns_i  = r;
        weights_i  = w;
        capital_i  = cap;
        clear_i    = clr;
        valid_in_i = 1'b1;
        tick();
        valid_in_i = 1'b0;
        clear_i    = 1'b0;
        lat = 0;
        while (valid_out_o !== 1'b1 && lat < 40) begin
            if (noise) begin
                valid_in_i = 1'($urandom_range(0, 1));
                returns_i  = N*16'($urandom);
            end
            tick();
            lat++;
        end
        if (valid_out_o !== 1'b1) check("valid_out_wait", valid_out_o, 1);
        val = longint'($signed(value_o));
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                valid_in_i = 1'($urandom_range(0, 1));
                returns_i  = N*16'($urandom);
            end
            tick();
        end
        valid_in_i = 1'b0;
        ready_in_i = 1'b1;
        tick();
        ready_in_i = 1'b0;
    endtask

    function automatic int rand_ret();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 80)) - 40;
            1:       v = int'($urandom_range(0, 65535)) - 32768;
            2:       v = int'($urandom_range(0, 20)) - 266;
            default: v = 0;
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     lat;
        longint val;

        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_value", $signed(value_o), 0);
        check("rst_valid_out", valid_out_o, 0);
        check("rst_ready_out", ready_out_o, 1);
        check("rst_step", step_count_o, 0);
        for (int i = 0; i < N; i++) check("rst_growth", lane_of(growth_o, i), 256);

        // Equal weights, zero returns
        run_step(pack3(0, 0, 0), pack3(85, 85, 85), 16'd10000, 1'b1, 0, 1'b0, lat, val);
        check("t1_latency", lat, 8);
        check("t1_value", val, 9960);
        check("t1_model_value", m_value, 9960);

        // Two +26 steps on lane 0
        run_step(pack3(26, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b1, 1, 1'b0, lat, val);
        check("t2_value_a", val, 11015);
        check("t2_g0_a", lane_of(growth_o, 0), 282);
        run_step(pack3(26, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b0, 0, 1'b0, lat, val);
        check("t2_value_b", val, 12109);
        check("t2_model_value_b", m_value, 12109);
        check("t2_g0_b", lane_of(growth_o, 0), 310);
        check("t2_step", step_count_o, 2);

        // Total loss clamps the factor at zero, and zero stays zero
        run_step(pack3(-300, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b1, 0, 1'b0, lat, val);
        check("t3_g0", lane_of(growth_o, 0), 0);
        check("t3_value", val, 0);
        run_step(pack3(100, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b0, 0, 1'b0, lat, val);
        check("t3_g0_stuck", lane_of(growth_o, 0), 0);
        run_step(pack3(-256, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b1, 0, 1'b0, lat, val);
        check("t3_g0_m256", lane_of(growth_o, 0), 0);

        // Overflowing growth factor
        run_step(pack3(32767, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b1, 0, 1'b0, lat, val);
        check("t4_g0", lane_of(growth_o, 0), T4_G0);

        // Downstream stall with ignored valid_in pulses
        run_step(pack3(10, -5, 3), pack3(100, 50, 25), 16'd777, 1'b0, 5, 1'b1, lat, val);
        check("t5_ready_after", ready_out_o, 1);
        check("t5_valid_after", valid_out_o, 0);

        // Reset in the middle of WEIGHT
        wait_ready();
        returns_i  = pack3(50, -20, 7);
        weights_i  = pack3(256, 256, 256);
        capital_i  = 16'd1000;
        valid_in_i = 1'b1;
        tick();
        valid_in_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) check("t6_rst_growth", lane_of(growth_o, i), 256);
        check("t6_rst_valid", valid_out_o, 0);
        check("t6_rst_step", step_count_o, 0);
        check("t6_rst_ready", ready_out_o, 1);
        run_step(pack3(100, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b0, 0, 1'b0, lat, val);
        check("t6_g0_pre", lane_of(growth_o, 0), 356);
        run_step(pack3(26, 0, 0), pack3(256, 0, 0), 16'd10000, 1'b1, 0, 1'b0, lat, val);
        check("t6_clear_accept_g0", lane_of(growth_o, 0), 282);
        check("t6_clear_accept_step", step_count_o, 1);

        // Randomized steps
        for (int s = 0; s < 60; s++) begin
            run_step(pack3(rand_ret(), rand_ret(), rand_ret()),
                     N*16'($urandom),
                     16'($urandom),
                     ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     lat, val);
            check("rand_latency", lat, 2 * N + 2);
        end

        // step_count saturation
        for (int s = 0; s < 260; s++) begin
            run_step(pack3(1, 2, 3), pack3(1, 1, 1), 16'd5, (s == 0), 0, 1'b0, lat, val);
        end
        check("step_saturate", step_count_o, 255);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
